// File: rtl/axi4lite_seq_master.sv
// rtl/axi4lite_seq_master.sv - AXI4-Lite write/readback self-test master
// Writes NUM_XFERS incrementing words, reads them back and reports pass plus a saturating error count.
module axi4lite_seq_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_XFERS          = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0] START_DATA         = 32'h0000_0001,
  parameter int                            TIMEOUT            = 1023
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [7:0]                    err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, FINISH} state_t;

  state_t                          state, state_next;
  logic [2:0]                      idx;
  logic                            aw_done, w_done;
  logic [TW-1:0]                   tmo_cnt;
  logic [7:0]                      err_q;
  logic                            pass_q;
  logic                            last, tmo_hit;
  logic                            run_start, err_inc, idx_clr, idx_inc;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_i;
  logic [C_M_AXI_DATA_WIDTH-1:0]   data_i;

  assign last    = (idx == 3'(NUM_XFERS - 1));
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT));
  assign addr_i  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign data_i  = START_DATA + C_M_AXI_DATA_WIDTH'(idx);

  assign M_AXI_AWADDR = addr_i;
  assign M_AXI_ARADDR = addr_i;
  assign M_AXI_WDATA  = data_i;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

  assign busy    = (state == WR_ADDR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);
  assign done    = (state == FINISH);
  assign pass    = (state == FINISH) ? (err_q == 8'd0) : pass_q;
  assign err_cnt = err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    run_start     = 1'b0;
    err_inc       = 1'b0;
    idx_clr       = 1'b0;
    idx_inc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = WR_ADDR;
          run_start  = 1'b1;
          idx_clr    = 1'b1;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; each VALID drops after its own handshake
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
        if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) begin
          state_next = WR_RESP;
        end else if (tmo_hit) begin
          state_next = FINISH;
          err_inc    = 1'b1;
        end
      end
      WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          err_inc = (M_AXI_BRESP != 2'b00);
          if (last) begin
            state_next = RD_ADDR;
            idx_clr    = 1'b1;
          end else begin
            state_next = WR_ADDR;
            idx_inc    = 1'b1;
          end
        end else if (tmo_hit) begin
          state_next = FINISH;
          err_inc    = 1'b1;
        end
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_next = RD_DATA;
        end else if (tmo_hit) begin
          state_next = FINISH;
          err_inc    = 1'b1;
        end
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          err_inc = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != data_i);
          if (last) begin
            state_next = FINISH;
          end else begin
            state_next = RD_ADDR;
            idx_inc    = 1'b1;
          end
        end else if (tmo_hit) begin
          state_next = FINISH;
          err_inc    = 1'b1;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      tmo_cnt <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (state_next != state) begin
        tmo_cnt <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (busy)                          tmo_cnt <= tmo_cnt + 1'b1;
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
      end
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (run_start)                        err_q <= '0;
      else if (err_inc && err_q != 8'hFF)   err_q <= err_q + 1'b1;
      if (run_start)              pass_q <= 1'b0;
      else if (state == FINISH)   pass_q <= (err_q == 8'd0);
    end
  end
endmodule

// File: tb/tb_axi4lite_seq_master.sv
// tb/tb_axi4lite_seq_master.sv - directed scoreboard bench for axi4lite_seq_master
// Negedge-driven AXI-Lite slave model with knobs for AW delay, bad read data, SLVERR and stalled AR.
module tb_axi4lite_seq_master;
  localparam int NX  = 4;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  axi4lite_seq_master #(.NUM_XFERS(NX), .TIMEOUT(TMO)) dut (
    .ACLK(clk), .ARESET(rst), .start(start), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int          passed = 0, total = 0;
  int          aw_delay = 0, aw_wait = 0, awv_cyc = 0, wv_cyc = 0;
  bit          bad_rd = 0, slverr_w0 = 0, ar_block = 0;
  bit          aw_have = 0, w_have = 0, ar_have = 0, b_fire = 0, r_fire = 0;
  logic [31:0] aw_l, wd_l, ar_l;
  logic [31:0] mem [8];
  logic [63:0] wr_log[$], exp_w[$];
  logic [31:0] rd_log[$], exp_r[$];

  // A READY raised at a negedge while VALID is high guarantees the handshake on the next posedge
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0; aw_wait = 0;
    end else begin
      if (b_fire) bvalid = 0;
      if (r_fire) rvalid = 0;
      awready = 0; wready = 0; arready = 0;
      if (aw_have && w_have && !bvalid) begin
        mem[aw_l[4:2]] = wd_l;
        wr_log.push_back({aw_l, wd_l});
        bresp  = (slverr_w0 && aw_l == 32'h0) ? 2'b10 : 2'b00;
        bvalid = 1; aw_have = 0; w_have = 0;
      end
      if (ar_have && !rvalid) begin
        rdata  = (bad_rd && ar_l == 32'h8) ? 32'h0000_DEAD : mem[ar_l[4:2]];
        rresp  = 2'b00;
        rvalid = 1; ar_have = 0;
        rd_log.push_back(ar_l);
      end
      if (awvalid) begin
        awv_cyc++;
        if (aw_wait >= aw_delay) begin awready = 1; aw_l = awaddr; aw_have = 1; aw_wait = 0; end
        else aw_wait++;
      end
      if (wvalid) begin wv_cyc++; wready = 1; wd_l = wdata; w_have = 1; end
      if (arvalid && !ar_block) begin arready = 1; ar_l = araddr; ar_have = 1; end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic prep(input int dly, input bit bad, input bit serr, input bit blk);
    aw_delay = dly; bad_rd = bad; slverr_w0 = serr; ar_block = blk;
    awv_cyc = 0; wv_cyc = 0; aw_wait = 0;
    wr_log.delete(); rd_log.delete(); exp_w.delete(); exp_r.delete();
    for (int i = 0; i < 8; i++) mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < NX; i++) begin
      exp_w.push_back({32'(4 * i), 32'(1 + i)});
      if (!blk) exp_r.push_back(32'(4 * i));
    end
  endtask

  task automatic check_sb(input string tag);
    logic [63:0] g;
    logic [31:0] r;
    while (exp_w.size() > 0) begin
      if (wr_log.size() > 0) g = wr_log.pop_front(); else g = 'x;
      check({tag, "_wr"}, g, exp_w.pop_front());
    end
    check({tag, "_wr_extra"}, 64'(wr_log.size()), 64'd0);
    while (exp_r.size() > 0) begin
      if (rd_log.size() > 0) r = rd_log.pop_front(); else r = 'x;
      check({tag, "_rd_addr"}, {32'h0, r}, {32'h0, exp_r.pop_front()});
    end
    check({tag, "_rd_extra"}, 64'(rd_log.size()), 64'd0);
  endtask

  // cyc counts the start cycle as 1; returns at the negedge where done is seen
  task automatic run_test(input int repulse, output int cyc, output bit busy_gap);
    busy_gap = 0;
    @(negedge clk); start = 1; cyc = 1;
    while (cyc < 5000) begin
      @(negedge clk); cyc++;
      if (done) break;
      if (busy !== 1'b1) busy_gap = 1;
      start = (cyc == repulse);
    end
    start = 0;
  endtask

  initial begin
    int cyc, n;
    bit gap;
    #3;
    check("rst_status", {busy, done, pass, err_cnt}, 64'd0);
    check("rst_bus", {awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("const_prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
    repeat (2) @(negedge clk);
    rst = 0;

    prep(0, 0, 0, 0);
    run_test(0, cyc, gap);
    check("t1_latency", cyc, 18);
    check("t1_busy", gap, 0);
    check("t1_pass", pass, 1);
    check("t1_err", err_cnt, 0);
    check("t1_bus_idle", {awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check_sb("t1");
    @(negedge clk);
    check("t1_done_pulse", {done, busy}, 64'd0);
    check("t1_pass_hold", pass, 1);

    prep(3, 0, 0, 0);
    run_test(0, cyc, gap);
    check("t2_latency", cyc, 30);
    check("t2_awvalid_cycles", awv_cyc, 16);
    check("t2_wvalid_cycles", wv_cyc, 4);
    check("t2_pass_err", {pass, err_cnt}, {1'b1, 8'd0});
    check_sb("t2");

    prep(0, 1, 0, 0);
    run_test(0, cyc, gap);
    check("t3_latency", cyc, 18);
    check("t3_pass_err", {pass, err_cnt}, {1'b0, 8'd1});
    check_sb("t3");
    repeat (5) @(negedge clk);
    check("t3_hold", {busy, pass, err_cnt}, {1'b0, 1'b0, 8'd1});

    prep(0, 0, 1, 1);
    run_test(0, cyc, gap);
    check("t4_latency", cyc, 1 + 2 * NX + TMO + 1 + 1);
    check("t4_busy", gap, 0);
    check("t4_pass_err", {pass, err_cnt}, {1'b0, 8'd2});
    check("t4_bus_idle", {awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check_sb("t4");

    prep(0, 0, 0, 0);
    run_test(6, cyc, gap);
    check("t5_latency", cyc, 18);
    check("t5_busy", gap, 0);
    check("t5_pass_err", {pass, err_cnt}, {1'b1, 8'd0});
    check_sb("t5");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_rerun", {busy, done}, 64'd0);
    end

    prep(0, 0, 0, 0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    n = 0;
    while (rready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("t6_reached_rd_data", rready, 1);
    #2 rst = 1;
    #1;
    check("t6_async_bus", {awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("t6_async_status", {busy, done, pass, err_cnt}, 64'd0);
    @(negedge clk);
    @(negedge clk); rst = 0;
    prep(0, 0, 0, 0);
    run_test(0, cyc, gap);
    check("t6_latency", cyc, 18);
    check("t6_pass_err", {pass, err_cnt}, {1'b1, 8'd0});
    check_sb("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi4lite_seq_master.md
Name: axi4lite_seq_master

Overview:
- AXI4-Lite master that exercises the eight-register slave in hardware, upstream of it on the same bus.
- On a start pulse it writes NUM_XFERS incrementing words to consecutive registers, reads them back, compares, and reports pass/fail plus an error count.
- Used as a power-on self-test and bring-up aid in front of the register bank. Software reads the status outputs later.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: address width.
- C_M_AXI_DATA_WIDTH, 32: data width. Fixed at 32.
- NUM_XFERS, 4: number of registers tested (1..8).
- BASE_ADDR, 32'h0000_0000: first register address. Stride is 4 bytes.
- START_DATA, 32'h0000_0001: first write value. Increments by 1 per register.
- TIMEOUT, 1023: maximum wait cycles per handshake phase.

Ports:
- ACLK  in  1  bus clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a test run
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run; held until the next accepted start
- err_cnt  out  8  mismatches + bad responses + timeouts in last run; saturates at 255
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1; AWREADY in 1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; WREADY in 1
- M_AXI_BRESP in 2, BVALID in 1, BREADY out 1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1; ARREADY in 1
- M_AXI_RDATA in 32, RRESP in 2, RVALID in 1, RREADY out 1

Behaviour:
- Reset (async, immediate):
  - State IDLE; all VALID and READY outputs 0; busy=0, done=0, pass=0, err_cnt=0.
  - Index and timeout counters = 0.
- Constant outputs: AWPROT=ARPROT=3'b000, WSTRB=4'hF.
- Address for index i is BASE_ADDR + 4*i, wrapping modulo 2^ADDR_WIDTH. Data for index i is START_DATA + i, modulo 2^32.
- IDLE:
  - start=1 → WR_ADDR.
  - On the same edge: clear err_cnt and pass, set index=0, set busy=1.
  - start is ignored in every other state.
- WR_ADDR:
  - Assert AWVALID and WVALID together in the same cycle.
  - Deassert each one independently on its own handshake (VALID&READY).
  - Once both handshakes are complete → WR_RESP.
  - VALID is never dropped before its handshake, and address/data are stable while VALID is high.
- WR_RESP:
  - BREADY=1. On BVALID: if BRESP≠OKAY, increment err_cnt.
  - If index=NUM_XFERS-1: set index=0 → RD_ADDR. Otherwise index+1 → WR_ADDR.
- RD_ADDR: ARVALID=1 until ARREADY → RD_DATA.
- RD_DATA:
  - RREADY=1. On RVALID: increment err_cnt by 1 if RRESP≠OKAY or RDATA≠expected (a single increment if both apply).
  - If last index → FINISH. Otherwise index+1 → RD_ADDR.
- FINISH (1 cycle): done=1, busy=0, pass=(err_cnt==0) → IDLE.
- Timeout:
  - Counter clears on every state change.
  - If it reaches TIMEOUT in WR_ADDR, WR_RESP, RD_ADDR or RD_DATA: increment err_cnt, drop all VALID/READY, go to FINISH. The run is aborted.
- Minimum latency with a zero-wait slave: start → done = 1 + NUM_XFERS*2 + NUM_XFERS*2 + 1 cycles (4-cycle write+read pair per register).
- Error counting is saturating: err_cnt stops at 255.
- A response arriving in the same cycle as its READY is accepted; early VALID from the slave is tolerated.
- Asserting ARESET mid-transaction abandons the run. No retry after release; the next start begins a fresh run.

Test Plan:
- Zero-wait AXI-Lite register-bank model, NUM_XFERS=4, start pulse → writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done after 18 cycles; pass=1, err_cnt=0.
- AWREADY delayed 3 cycles while WREADY is immediate → WVALID drops after 1 cycle and AWVALID is held 4; both values accepted correctly; pass=1.
- Slave returns RDATA 0xDEAD at address 0x8 → err_cnt=1, pass=0, done still pulses.
- Slave returns BRESP=SLVERR on write 0 and never asserts ARREADY → err_cnt=2 (error + timeout), done after TIMEOUT; all VALIDs=0.
- start pulsed again while busy → ignored; pass/err_cnt unchanged until the first run completes.
- ARESET asserted during RD_DATA → all outputs 0 asynchronously; after release, start → full passing run.
